deit_gemm_core: RTL and testbench
=================================

Name: deit_gemm_core

Overview:
Int8 GEMM tile engine for the DeiT accelerator. It sits between the input (activation) buffer and the weight buffer controllers, and owns a weight-stationary 12x16 systolic MAC array plus 16 accumulator banks.
- Per run: requests and loads a 12x16 weight tile, streams M activation rows, and writes each 16-wide int32 result row to accumulator address m.
- Each write either overwrites or adds, so K-blocking is done by back-to-back runs.

Parameters:
ARRAY_ROW, 12, K depth of the tile (activation bytes per row, PE rows)
ARRAY_COL, 16, N width (weight bytes per row, output columns, accumulator banks)
LATENCY_CFG, 28, cycles from the ctrl_input_stream_en cycle of row m to its result at the array output
ADDR_WIDTH, 8, accumulator bank depth = 2^ADDR_WIDTH words
DMA_WAIT_CYCLES, 32, cycles ctrl_weight_dma_req is held before weight loading starts

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous reset, ACTIVE-HIGH (name kept per codebase convention)
ap_start  in  1  start pulse, honoured only when idle
cfg_compute_cycles  in  32  M = activation rows this run, sampled at start
cfg_acc_mode  in  1  0 overwrite, 1 accumulate; sampled at start
in_act_vec  in  ARRAY_ROW*8  activation row, byte k = A[m][k], signed
in_weight_vec  in  ARRAY_COL*8  weight row, byte n = W[k][n], signed
ap_done  out  1  one-cycle pulse at run end
ap_idle  out  1  high in IDLE
out_acc_vec  out  ARRAY_COL*32  last accumulator word written, bank n in bits [32n+31:32n]
ctrl_weight_dma_req  out  1  weight DMA request, level
ctrl_weight_load_en  out  1  pops one weight row per cycle
ctrl_input_stream_en  out  1  pops one activation row per cycle

Behaviour:
- Reset: state IDLE, all outputs 0 except ap_idle=1. PE weights, pipelines and counters are cleared; accumulator memory contents are undefined.
- Buffers have registered reads: data appears one cycle after the enable cycle.
- IDLE:
  - On ap_start, latch M and mode, then go to DMA_WAIT.
  - ap_start is ignored in every other state.
- DMA_WAIT: ctrl_weight_dma_req=1 for DMA_WAIT_CYCLES cycles, then LOAD_W.
- LOAD_W:
  - ctrl_weight_load_en=1 for ARRAY_ROW cycles.
  - The in_weight_vec arriving one cycle after the r-th enable is latched as PE row r (r=0..11).
  - Then COMPUTE, or DRAIN if M=0.
- COMPUTE: ctrl_input_stream_en=1 for exactly M consecutive cycles, row m on cycle m.
- Array: result[n] = sum over k of A[m][k]*W[k][n].
  - 8x8 signed multiply, 32-bit signed accumulate, two's-complement wrap, no saturation.
  - Internal skew/deskew makes result row m valid exactly LATENCY_CFG cycles after its stream_en cycle.
- Accumulator write, bank n, address m mod 2^ADDR_WIDTH:
  - Overwrite mode: mem = result.
  - Accumulate mode: mem = mem + result.
  - Read-modify-write has no hazard because the address is distinct each cycle.
- DRAIN: wait until the last write commits, then DONE.
- DONE: ap_done=1 for one cycle, then IDLE.
- out_acc_vec is updated with the written values on each write cycle and holds otherwise.
- M > 2^ADDR_WIDTH: addresses wrap and later rows update earlier words.
- Reset mid-run: returns to IDLE next cycle, no ap_done, in-flight writes are discarded.

Decomposition:
- Package deit_pkg: ARRAY_ROW, ARRAY_COL, ACC_W=32, state enum {IDLE, DMA_WAIT, LOAD_W, COMPUTE, DRAIN, DONE}.
- One sub-module deit_mac_pe: weight register, int8 multiply, partial-sum add, activation/psum pass registers.
- The array is a generate of 12x16 deit_mac_pe.
- Accumulator banks are instantiated as 16 per-column arrays named gen_banks[n].u_bank.mem so benches can peek them hierarchically.

Test Plan:
- All A=1, all W=1, M=18, overwrite -> mem[0..17] in every bank = 12. ap_done pulses once; ap_idle returns high.
- Repeat the same run in accumulate mode -> every word = 24. Then an overwrite run with A=2 -> every word = 24 (old value discarded).
- Signed extremes: A=-128, W=127, M=1 -> 12*(-16256) = -195072 in all banks. A=-128, W=-128 -> 196608.
- Latency/ordering:
  - A row m = m+1 in every byte, W column n = n in every row (W[k][n]=n), M=18.
  - First write is exactly LATENCY_CFG cycles after the first stream_en cycle.
  - mem[m] of bank n = 12*(m+1)*n.
  - stream_en high exactly 18 cycles; load_en high exactly 12 cycles.
- Blocked GEMM, two batches of two K tiles, overwrite then accumulate -> matches the software int32 golden model for 36x24x16.
- Robustness:
  - ap_start pulsed during COMPUTE -> ignored, only one ap_done.
  - Reset asserted mid-COMPUTE -> IDLE next cycle, outputs 0, no ap_done.
  - M=0 -> ap_done follows weight load, no stream_en.

Source files
------------

// File: rtl/deit_gemm_core_pkg.sv
// Shared sizing constants and FSM state encoding for the DeiT int8 GEMM tile engine.
package deit_pkg;

    localparam int unsigned ARRAY_ROW       = 12;
    localparam int unsigned ARRAY_COL       = 16;
    localparam int unsigned ACC_W           = 32;
    localparam int unsigned ADDR_WIDTH      = 8;
    localparam int unsigned ACC_DEPTH       = 2 ** ADDR_WIDTH;
    localparam int unsigned DMA_WAIT_CYCLES = 32;
    localparam int unsigned ROW_IDX_W       = $clog2(ARRAY_ROW);
    // Skew (k) + PE row hops + deskew (15-n) always sum to ROW+COL cycles.
    localparam int unsigned LATENCY_CFG     = ARRAY_ROW + ARRAY_COL;

    typedef enum logic [2:0] {
        IDLE,
        DMA_WAIT,
        LOAD_W,
        COMPUTE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/deit_mac_pe.sv
// Weight-stationary MAC cell: holds one int8 weight, forwards the activation east
// and the partial sum south, each through one register.
module deit_mac_pe
    import deit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_w_ld,
    input  logic [7:0]       i_w,
    input  logic [7:0]       i_a,
    input  logic [ACC_W-1:0] i_psum,
    output logic [7:0]       o_a,
    output logic [ACC_W-1:0] o_psum
);

    logic [7:0]         r_w;
    logic [7:0]         r_a;
    logic [ACC_W-1:0]   r_psum;
    logic signed [15:0] w_prod;

    assign w_prod = $signed(i_a) * $signed(r_w);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_w    <= '0;
            r_a    <= '0;
            r_psum <= '0;
        end else begin
            if (i_w_ld) begin
                r_w <= i_w;
            end
            r_a    <= i_a;
            r_psum <= i_psum + {{(ACC_W-16){w_prod[15]}}, w_prod};
        end
    end

    assign o_a    = r_a;
    assign o_psum = r_psum;

endmodule

// File: rtl/deit_gemm_core.sv
// Int8 GEMM tile engine: loads a 12x16 weight tile, streams M activation rows through
// a systolic array and overwrites/accumulates each 16-wide int32 row into its banks.
module deit_gemm_core
    import deit_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ap_start,
    input  logic [31:0]                cfg_compute_cycles,
    input  logic                       cfg_acc_mode,
    input  logic [ARRAY_ROW*8-1:0]     in_act_vec,
    input  logic [ARRAY_COL*8-1:0]     in_weight_vec,
    output logic                       ap_done,
    output logic                       ap_idle,
    output logic [ARRAY_COL*ACC_W-1:0] out_acc_vec,
    output logic                       ctrl_weight_dma_req,
    output logic                       ctrl_weight_load_en,
    output logic                       ctrl_input_stream_en
);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [31:0]                r_cnt;
    logic [31:0]                w_cnt_nxt;
    logic [31:0]                r_m;
    logic                       r_acc_mode;
    logic                       r_ap_done;
    logic                       r_ap_idle;
    logic                       r_dma_req;
    logic                       r_load_en;
    logic                       r_stream_en;
    logic                       r_ld_vld;
    logic [ROW_IDX_W-1:0]       r_ld_row;
    logic [LATENCY_CFG-1:0]     r_vld_sr;
    logic [ADDR_WIDTH-1:0]      r_wr_addr;
    logic [ARRAY_COL*ACC_W-1:0] r_out;
    logic                       w_wr_en;

    logic [7:0]       w_a       [ARRAY_ROW][ARRAY_COL+1];
    logic [ACC_W-1:0] w_ps      [ARRAY_ROW+1][ARRAY_COL];
    logic [ACC_W-1:0] w_res     [ARRAY_COL];
    logic [ACC_W-1:0] w_wr_data [ARRAY_COL];

    // State register, run configuration and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_m         <= '0;
            r_acc_mode  <= 1'b0;
            r_ap_done   <= 1'b0;
            r_ap_idle   <= 1'b1;
            r_dma_req   <= 1'b0;
            r_load_en   <= 1'b0;
            r_stream_en <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if ((r_state == IDLE) && ap_start) begin
                r_m        <= cfg_compute_cycles;
                r_acc_mode <= cfg_acc_mode;
            end
            r_ap_done   <= (w_state_nxt == DONE);
            r_ap_idle   <= (w_state_nxt == IDLE);
            r_dma_req   <= (w_state_nxt == DMA_WAIT);
            r_load_en   <= (w_state_nxt == LOAD_W);
            r_stream_en <= (w_state_nxt == COMPUTE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (ap_start) begin
                    w_state_nxt = DMA_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            DMA_WAIT: begin
                if (r_cnt == 32'(DMA_WAIT_CYCLES - 1)) begin
                    w_state_nxt = LOAD_W;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            LOAD_W: begin
                if (r_cnt == 32'(ARRAY_ROW - 1)) begin
                    w_state_nxt = (r_m == '0) ? DRAIN : COMPUTE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            COMPUTE: begin
                if (r_cnt + 32'd1 == r_m) begin
                    w_state_nxt = DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            DRAIN: begin
                if (r_vld_sr == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Weight row r arrives the cycle after its load enable; result valid tracks stream_en.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_ld_vld  <= 1'b0;
            r_ld_row  <= '0;
            r_vld_sr  <= '0;
            r_wr_addr <= '0;
            r_out     <= '0;
        end else begin
            r_ld_vld <= (r_state == LOAD_W);
            r_ld_row <= r_cnt[ROW_IDX_W-1:0];
            r_vld_sr <= {r_vld_sr[LATENCY_CFG-2:0], r_stream_en};
            if ((r_state == IDLE) && ap_start) begin
                r_wr_addr <= '0;
            end else if (w_wr_en) begin
                r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
            end
            if (w_wr_en) begin
                for (int n = 0; n < ARRAY_COL; n++) begin
                    r_out[ACC_W*n +: ACC_W] <= w_wr_data[n];
                end
            end
        end
    end

    // A write landing in the reset cycle is dropped.
    assign w_wr_en = r_vld_sr[LATENCY_CFG-1] & ~rst_n;

    for (genvar k = 0; k < ARRAY_ROW; k++) begin : gen_skew
        if (k == 0) begin : g_direct
            assign w_a[k][0] = in_act_vec[7:0];
        end else begin : g_dly
            logic [7:0] r_dly [k];
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    r_dly <= '{default: '0};
                end else begin
                    r_dly[0] <= in_act_vec[8*k +: 8];
                    for (int i = 1; i < k; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end
            assign w_a[k][0] = r_dly[k-1];
        end
    end

    for (genvar n = 0; n < ARRAY_COL; n++) begin : gen_ps_top
        assign w_ps[0][n] = '0;
    end

    for (genvar k = 0; k < ARRAY_ROW; k++) begin : gen_row
        for (genvar n = 0; n < ARRAY_COL; n++) begin : gen_col
            deit_mac_pe u_pe (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_w_ld (r_ld_vld && (r_ld_row == ROW_IDX_W'(k))),
                .i_w    (in_weight_vec[8*n +: 8]),
                .i_a    (w_a[k][n]),
                .i_psum (w_ps[k][n]),
                .o_a    (w_a[k][n+1]),
                .o_psum (w_ps[k+1][n])
            );
        end
    end

    // Column n leaves the array n cycles late; delay it so all columns align.
    for (genvar n = 0; n < ARRAY_COL; n++) begin : gen_deskew
        localparam int unsigned D = ARRAY_COL - 1 - n;
        if (D == 0) begin : g_direct
            assign w_res[n] = w_ps[ARRAY_ROW][n];
        end else begin : g_dly
            logic [ACC_W-1:0] r_dly [D];
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    r_dly <= '{default: '0};
                end else begin
                    r_dly[0] <= w_ps[ARRAY_ROW][n];
                    for (int i = 1; i < int'(D); i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end
            assign w_res[n] = r_dly[D-1];
        end
    end

    for (genvar n = 0; n < ARRAY_COL; n++) begin : gen_banks
        if (1'b1) begin : u_bank
            logic [ACC_W-1:0] mem [ACC_DEPTH];
            assign w_wr_data[n] = r_acc_mode ? (mem[r_wr_addr] + w_res[n]) : w_res[n];
            always_ff @(posedge clk) begin
                if (w_wr_en) begin
                    mem[r_wr_addr] <= w_wr_data[n];
                end
            end
        end
    end

    assign ap_done              = r_ap_done;
    assign ap_idle              = r_ap_idle;
    assign out_acc_vec          = r_out;
    assign ctrl_weight_dma_req  = r_dma_req;
    assign ctrl_weight_load_en  = r_load_en;
    assign ctrl_input_stream_en = r_stream_en;

endmodule

// File: tb/tb_deit_gemm_core.sv
// Self-checking bench for deit_gemm_core: buffer models feed rows, a scoreboard
// predicts each written accumulator row and its cycle.
module tb_deit_gemm_core;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ap_start;
    logic [31:0]  cfg_compute_cycles;
    logic         cfg_acc_mode;
    logic [95:0]  in_act_vec;
    logic [127:0] in_weight_vec;
    logic         ap_done;
    logic         ap_idle;
    logic [511:0] out_acc_vec;
    logic         ctrl_weight_dma_req;
    logic         ctrl_weight_load_en;
    logic         ctrl_input_stream_en;

    always #5 clk = ~clk;

    deit_gemm_core dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ap_start             (ap_start),
        .cfg_compute_cycles   (cfg_compute_cycles),
        .cfg_acc_mode         (cfg_acc_mode),
        .in_act_vec           (in_act_vec),
        .in_weight_vec        (in_weight_vec),
        .ap_done              (ap_done),
        .ap_idle              (ap_idle),
        .out_acc_vec          (out_acc_vec),
        .ctrl_weight_dma_req  (ctrl_weight_dma_req),
        .ctrl_weight_load_en  (ctrl_weight_load_en),
        .ctrl_input_stream_en (ctrl_input_stream_en)
    );

    typedef struct {
        int           due;
        logic [511:0] exp;
    } sb_t;

    sb_t          sb[$];
    logic [95:0]  act_rows[$];
    logic [127:0] w_rows[12];
    logic [31:0]  model_mem[16][256];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           act_idx, ld_idx, s_idx;
    int           n_load, n_stream, n_done, n_dma;
    bit           prev_load, prev_stream, run_mode, sb_mute;
    logic [511:0] mon_res, mon_exp;
    logic [31:0]  mon_word;
    int           mon_addr;

    logic signed [7:0] ga[36][24];
    logic signed [7:0] gb[24][16];
    int                gc[36][16];

    function automatic logic [95:0] act_fill(input logic [7:0] b);
        logic [95:0] v;
        for (int k = 0; k < 12; k++) v[8*k +: 8] = b;
        return v;
    endfunction

    function automatic logic [127:0] w_fill(input logic [7:0] b);
        logic [127:0] v;
        for (int n = 0; n < 16; n++) v[8*n +: 8] = b;
        return v;
    endfunction

    function automatic logic [511:0] row_result(input logic [95:0] a);
        logic [511:0] r;
        int           acc;
        for (int n = 0; n < 16; n++) begin
            acc = 0;
            for (int k = 0; k < 12; k++)
                acc += int'($signed(a[8*k +: 8])) * int'($signed(w_rows[k][8*n +: 8]));
            r[32*n +: 32] = acc;
        end
        return r;
    endfunction

    // Registered-read buffer models plus the write scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (prev_load) begin
            if (ld_idx < 12) in_weight_vec = w_rows[ld_idx];
            ld_idx++;
        end
        if (prev_stream) begin
            if (act_idx < act_rows.size()) in_act_vec = act_rows[act_idx];
            act_idx++;
        end
        prev_load   = ctrl_weight_load_en;
        prev_stream = ctrl_input_stream_en;
        if (ctrl_weight_load_en) n_load++;
        if (ctrl_weight_dma_req) n_dma++;
        if (ap_done) n_done++;
        if (ctrl_input_stream_en) begin
            n_stream++;
            if (!sb_mute) begin
                mon_res  = row_result((s_idx < act_rows.size()) ? act_rows[s_idx] : 96'd0);
                mon_addr = s_idx % 256;
                for (int n = 0; n < 16; n++) begin
                    mon_word = mon_res[32*n +: 32];
                    if (run_mode) mon_word = mon_word + model_mem[n][mon_addr];
                    model_mem[n][mon_addr] = mon_word;
                    mon_exp[32*n +: 32] = mon_word;
                end
                sb.push_back('{cyc + 29, mon_exp});
            end
            s_idx++;
        end
        if (!sb_mute && sb.size() > 0 && sb[0].due == cyc) begin
            n_checks++;
            if (out_acc_vec !== sb[0].exp) begin
                n_fail++;
                $display("FAIL sb_row cyc=%0d got=%h exp=%h", cyc, out_acc_vec, sb[0].exp);
            end
            void'(sb.pop_front());
        end
    end

    task automatic start_run(input int m, input bit mode);
        @(negedge clk);
        act_idx = 0; ld_idx = 0; s_idx = 0;
        n_load = 0; n_stream = 0; n_done = 0; n_dma = 0;
        run_mode = mode;
        cfg_compute_cycles = m;
        cfg_acc_mode = mode;
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (ap_done) begin ok = 1'b1; break; end
        end
        @(negedge clk);
    endtask

    task automatic run_gemm(input int m, input bit mode, output bit ok);
        start_run(m, mode);
        wait_done(ok);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got=%b exp=1", ap_idle); end
        n_checks++; if (ap_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", ap_done); end
        n_checks++; if (ctrl_weight_dma_req !== 1'b0) begin n_fail++; $display("FAIL reset_dma got=%b exp=0", ctrl_weight_dma_req); end
        n_checks++; if (ctrl_weight_load_en !== 1'b0) begin n_fail++; $display("FAIL reset_load got=%b exp=0", ctrl_weight_load_en); end
        n_checks++; if (ctrl_input_stream_en !== 1'b0) begin n_fail++; $display("FAIL reset_stream got=%b exp=0", ctrl_input_stream_en); end
        n_checks++; if (out_acc_vec !== 512'd0) begin n_fail++; $display("FAIL reset_out got=%h exp=0", out_acc_vec); end
        rst_n = 1'b0;
    endtask

    task automatic test_ones();
        bit ok;
        act_rows.delete();
        for (int m = 0; m < 18; m++) act_rows.push_back(act_fill(8'd1));
        for (int k = 0; k < 12; k++) w_rows[k] = w_fill(8'd1);
        run_gemm(18, 1'b0, ok);
        repeat (3) @(negedge clk);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ones_done_timeout got=%b exp=1", ok); end
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL ones_done_count got=%0d exp=1", n_done); end
        n_checks++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL ones_idle got=%b exp=1", ap_idle); end
        for (int m = 0; m < 18; m++) begin
            n_checks++;
            if (dut.gen_banks[7].u_bank.mem[m] !== 32'd12) begin
                n_fail++; $display("FAIL ones_mem7 addr=%0d got=%0d exp=12", m, dut.gen_banks[7].u_bank.mem[m]);
            end
        end
    endtask

    task automatic test_accumulate();
        bit ok;
        run_gemm(18, 1'b1, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL acc_done_timeout got=%b exp=1", ok); end
        n_checks++; if (dut.gen_banks[0].u_bank.mem[17] !== 32'd24) begin
            n_fail++; $display("FAIL acc_mem0 got=%0d exp=24", dut.gen_banks[0].u_bank.mem[17]); end
        act_rows.delete();
        for (int m = 0; m < 18; m++) act_rows.push_back(act_fill(8'd2));
        run_gemm(18, 1'b0, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ovw_done_timeout got=%b exp=1", ok); end
        n_checks++; if (dut.gen_banks[15].u_bank.mem[5] !== 32'd24) begin
            n_fail++; $display("FAIL ovw_mem15 got=%0d exp=24", dut.gen_banks[15].u_bank.mem[5]); end
    endtask

    task automatic test_signed();
        bit           ok;
        logic [511:0] e;
        act_rows.delete();
        act_rows.push_back(act_fill(8'h80));
        for (int k = 0; k < 12; k++) w_rows[k] = w_fill(8'h7f);
        run_gemm(1, 1'b0, ok);
        for (int n = 0; n < 16; n++) e[32*n +: 32] = -195072;
        n_checks++; if (ok !== 1'b1 || out_acc_vec !== e) begin
            n_fail++; $display("FAIL signed_neg got=%h exp=%h", out_acc_vec, e); end
        for (int k = 0; k < 12; k++) w_rows[k] = w_fill(8'h80);
        run_gemm(1, 1'b0, ok);
        for (int n = 0; n < 16; n++) e[32*n +: 32] = 196608;
        n_checks++; if (ok !== 1'b1 || out_acc_vec !== e) begin
            n_fail++; $display("FAIL signed_pos got=%h exp=%h", out_acc_vec, e); end
    endtask

    task automatic test_latency();
        bit           ok;
        bit           seen;
        int           lat;
        logic [511:0] old;
        act_rows.delete();
        for (int m = 0; m < 18; m++) act_rows.push_back(act_fill(8'(m + 1)));
        for (int k = 0; k < 12; k++)
            for (int n = 0; n < 16; n++) w_rows[k][8*n +: 8] = 8'(n);
        start_run(18, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ctrl_input_stream_en) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        old = out_acc_vec;
        lat = -1;
        for (int i = 1; i <= 60 && seen; i++) begin
            @(negedge clk);
            if (out_acc_vec !== old) begin lat = i; break; end
        end
        n_checks++; if (lat !== 29) begin
            n_fail++; $display("FAIL latency got=%0d exp=29 (write cycle +28, visible next)", lat); end
        wait_done(ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL lat_done_timeout got=%b exp=1", ok); end
        n_checks++; if (n_stream !== 18) begin n_fail++; $display("FAIL lat_stream_cycles got=%0d exp=18", n_stream); end
        n_checks++; if (n_load !== 12) begin n_fail++; $display("FAIL lat_load_cycles got=%0d exp=12", n_load); end
        n_checks++; if (n_dma !== 32) begin n_fail++; $display("FAIL lat_dma_cycles got=%0d exp=32", n_dma); end
        for (int m = 0; m < 18; m++) begin
            n_checks++;
            if (dut.gen_banks[1].u_bank.mem[m] !== 32'(12 * (m + 1))) begin
                n_fail++; $display("FAIL lat_mem1 addr=%0d got=%0d exp=%0d", m, dut.gen_banks[1].u_bank.mem[m], 12 * (m + 1)); end
            n_checks++;
            if (dut.gen_banks[15].u_bank.mem[m] !== 32'(12 * (m + 1) * 15)) begin
                n_fail++; $display("FAIL lat_mem15 addr=%0d got=%0d exp=%0d", m, dut.gen_banks[15].u_bank.mem[m], 12 * (m + 1) * 15); end
        end
    endtask

    task automatic test_blocked();
        bit           ok;
        logic [95:0]  v;
        logic [511:0] e;
        for (int i = 0; i < 36; i++)
            for (int k = 0; k < 24; k++) ga[i][k] = 8'($urandom);
        for (int k = 0; k < 24; k++)
            for (int n = 0; n < 16; n++) gb[k][n] = 8'($urandom);
        for (int i = 0; i < 36; i++)
            for (int n = 0; n < 16; n++) begin
                gc[i][n] = 0;
                for (int k = 0; k < 24; k++) gc[i][n] += int'(ga[i][k]) * int'(gb[k][n]);
            end
        for (int b = 0; b < 2; b++) begin
            for (int t = 0; t < 2; t++) begin
                act_rows.delete();
                for (int m = 0; m < 18; m++) begin
                    for (int k = 0; k < 12; k++) v[8*k +: 8] = ga[b*18 + m][t*12 + k];
                    act_rows.push_back(v);
                end
                for (int k = 0; k < 12; k++)
                    for (int n = 0; n < 16; n++) w_rows[k][8*n +: 8] = gb[t*12 + k][n];
                run_gemm(18, t[0], ok);
                n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL blk_done_timeout b=%0d t=%0d", b, t); end
            end
            for (int m = 0; m < 18; m++) begin
                n_checks++;
                if (dut.gen_banks[0].u_bank.mem[m] !== 32'(gc[b*18 + m][0])) begin
                    n_fail++; $display("FAIL blk_mem0 b=%0d m=%0d got=%0d exp=%0d", b, m, dut.gen_banks[0].u_bank.mem[m], gc[b*18 + m][0]); end
                n_checks++;
                if (dut.gen_banks[15].u_bank.mem[m] !== 32'(gc[b*18 + m][15])) begin
                    n_fail++; $display("FAIL blk_mem15 b=%0d m=%0d got=%0d exp=%0d", b, m, dut.gen_banks[15].u_bank.mem[m], gc[b*18 + m][15]); end
            end
            for (int n = 0; n < 16; n++) e[32*n +: 32] = gc[b*18 + 17][n];
            n_checks++; if (out_acc_vec !== e) begin
                n_fail++; $display("FAIL blk_last_row b=%0d got=%h exp=%h", b, out_acc_vec, e); end
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        bit seen;
        act_rows.delete();
        for (int m = 0; m < 30; m++) act_rows.push_back(act_fill(8'd3));
        for (int k = 0; k < 12; k++) w_rows[k] = w_fill(8'hff);
        start_run(30, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ctrl_input_stream_en) begin seen = 1'b1; break; end
        end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL ign_stream_timeout got=%b exp=1", seen); end
        cfg_compute_cycles = 5;
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        wait_done(ok);
        repeat (60) @(negedge clk);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ign_done_timeout got=%b exp=1", ok); end
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL ign_done_count got=%0d exp=1", n_done); end
        n_checks++; if (n_stream !== 30) begin n_fail++; $display("FAIL ign_stream_cycles got=%0d exp=30", n_stream); end
        n_checks++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL ign_idle got=%b exp=1", ap_idle); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        act_rows.delete();
        for (int m = 0; m < 40; m++) act_rows.push_back(act_fill(8'd1));
        for (int k = 0; k < 12; k++) w_rows[k] = w_fill(8'd1);
        start_run(40, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ctrl_input_stream_en) begin seen = 1'b1; break; end
        end
        repeat (32) @(negedge clk);
        n_checks++; if (seen !== 1'b1 || ctrl_input_stream_en !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_not_computing got=%b exp=1", ctrl_input_stream_en); end
        sb_mute = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        n_checks++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL rst_mid_idle got=%b exp=1", ap_idle); end
        n_checks++; if (ctrl_input_stream_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stream got=%b exp=0", ctrl_input_stream_en); end
        n_checks++; if (out_acc_vec !== 512'd0) begin n_fail++; $display("FAIL rst_mid_out got=%h exp=0", out_acc_vec); end
        @(negedge clk);
        sb.delete();
        sb_mute = 1'b0;
        n_done = 0;
        repeat (60) @(negedge clk);
        n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL rst_mid_done got=%0d exp=0", n_done); end
        n_checks++; if (out_acc_vec !== 512'd0) begin n_fail++; $display("FAIL rst_mid_no_write got=%h exp=0", out_acc_vec); end
    endtask

    task automatic test_m_zero();
        bit ok;
        act_rows.delete();
        run_gemm(0, 1'b0, ok);
        repeat (3) @(negedge clk);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL m0_done_timeout got=%b exp=1", ok); end
        n_checks++; if (n_stream !== 0) begin n_fail++; $display("FAIL m0_stream got=%0d exp=0", n_stream); end
        n_checks++; if (n_load !== 12) begin n_fail++; $display("FAIL m0_load got=%0d exp=12", n_load); end
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL m0_done_count got=%0d exp=1", n_done); end
        n_checks++; if (out_acc_vec !== 512'd0) begin n_fail++; $display("FAIL m0_out got=%h exp=0", out_acc_vec); end
    endtask

    initial begin
        rst_n = 1'b1; ap_start = 1'b0; cfg_compute_cycles = '0; cfg_acc_mode = 1'b0;
        in_act_vec = '0; in_weight_vec = '0;
        act_idx = 0; ld_idx = 0; s_idx = 0;
        n_load = 0; n_stream = 0; n_done = 0; n_dma = 0;
        prev_load = 1'b0; prev_stream = 1'b0; run_mode = 1'b0; sb_mute = 1'b0;
        test_reset();
        test_ones();
        test_accumulate();
        test_signed();
        test_latency();
        test_blocked();
        test_start_ignored();
        test_reset_mid();
        test_m_zero();
        n_checks++;
        if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
